// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot traffic-light lamp bus. It tracks the
// RED -> GREEN -> YELLOW sequence, enforces dwell bounds and counts completed cycles.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 2,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light_in,
  output logic [1:0]       cur_phase,
  output logic             err_illegal,
  output logic             err_sequence,
  output logic             err_dwell_short,
  output logic             err_dwell_long,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW_W = $clog2(MAX_DWELL + 2);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_t;

  phase_t            state, state_nx;
  phase_t            code_ph, succ_ph;
  logic              legal;
  logic [DW_W-1:0]   dwell, dwell_nx, dwell_inc;
  logic              exempt, exempt_nx;
  logic              ill_nx, seq_nx, short_nx, long_nx;
  logic [CNT_W-1:0]  cnt_nx;

  always_comb begin
    legal   = 1'b1;
    code_ph = SYNC;
    unique case (light_in)
      3'b100:  code_ph = RED;
      3'b010:  code_ph = GREEN;
      3'b001:  code_ph = YELLOW;
      default: legal   = 1'b0;
    endcase
  end

  always_comb begin
    unique case (state)
      RED:     succ_ph = GREEN;
      GREEN:   succ_ph = YELLOW;
      default: succ_ph = RED;
    endcase
  end

  assign dwell_inc = dwell + DW_W'(1);

  always_comb begin
    state_nx  = state;
    dwell_nx  = dwell;
    exempt_nx = exempt;
    ill_nx    = 1'b0;
    seq_nx    = 1'b0;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    cnt_nx    = cycle_count;

    if (state == SYNC) begin
      if (!legal) begin
        ill_nx = 1'b1;
      end else if (code_ph == RED) begin
        state_nx  = RED;
        dwell_nx  = DW_W'(1);
        exempt_nx = 1'b1;
      end
    end else if (!legal) begin
      ill_nx   = 1'b1;
      state_nx = SYNC;
      dwell_nx = '0;
    end else if (code_ph == state) begin
      dwell_nx = dwell_inc;
      if (dwell_inc == DW_W'(MAX_DWELL + 1)) begin
        long_nx  = 1'b1;
        state_nx = SYNC;
        dwell_nx = '0;
      end
    end else if (code_ph == succ_ph) begin
      if (dwell < DW_W'(MIN_DWELL) && !exempt) begin
        short_nx = 1'b1;
        state_nx = SYNC;
        dwell_nx = '0;
      end else begin
        // The phase entered from SYNC is the only exempt one; any advance clears it.
        if (state == YELLOW && cycle_count != '1)
          cnt_nx = cycle_count + CNT_W'(1);
        state_nx  = code_ph;
        dwell_nx  = DW_W'(1);
        exempt_nx = 1'b0;
      end
    end else begin
      seq_nx   = 1'b1;
      state_nx = SYNC;
      dwell_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SYNC;
      dwell           <= '0;
      exempt          <= 1'b0;
      err_illegal     <= 1'b0;
      err_sequence    <= 1'b0;
      err_dwell_short <= 1'b0;
      err_dwell_long  <= 1'b0;
      err_sticky      <= 1'b0;
      cycle_count     <= '0;
    end else begin
      state           <= state_nx;
      dwell           <= dwell_nx;
      exempt          <= exempt_nx;
      err_illegal     <= ill_nx;
      err_sequence    <= seq_nx;
      err_dwell_short <= short_nx;
      err_dwell_long  <= long_nx;
      err_sticky      <= err_sticky | ill_nx | seq_nx | short_nx | long_nx;
      cycle_count     <= cnt_nx;
    end
  end

  assign cur_phase = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed test-plan sequences followed by randomized lamp runs. Every output is
// compared each cycle against a rule-level reference model.
module tb_traffic_light_monitor;

  localparam int MIN_D = 2;
  localparam int MAX_D = 16;
  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light;
  logic [1:0] phase_a, phase_b;
  logic       ill_a, seq_a, short_a, long_a, sticky_a;
  logic       ill_b, seq_b, short_b, long_b, sticky_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_phase, m_dwell, m_cnt8, m_cnt2;
  bit m_exempt, m_sticky;
  bit m_ill, m_seq, m_short, m_long;

  always #5 clk = ~clk;

  traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .light_in(light), .cur_phase(phase_a),
    .err_illegal(ill_a), .err_sequence(seq_a), .err_dwell_short(short_a),
    .err_dwell_long(long_a), .err_sticky(sticky_a), .cycle_count(cnt_a)
  );

  traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .light_in(light), .cur_phase(phase_b),
    .err_illegal(ill_b), .err_sequence(seq_b), .err_dwell_short(short_b),
    .err_dwell_long(long_b), .err_sticky(sticky_b), .cycle_count(cnt_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lamp_phase(input logic [2:0] l);
    if (l == R) return 1;
    if (l == G) return 2;
    if (l == Y) return 3;
    return -1;
  endfunction

  function automatic void model_step(input logic [2:0] l, input bit r);
    int p;
    m_ill = 0; m_seq = 0; m_short = 0; m_long = 0;
    if (r) begin
      m_phase = 0; m_dwell = 0; m_exempt = 0; m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    p = lamp_phase(l);
    if (m_phase == 0) begin
      if (p < 0) m_ill = 1;
      else if (p == 1) begin m_phase = 1; m_dwell = 1; m_exempt = 1; end
    end else if (p < 0) begin
      m_ill = 1; m_phase = 0;
    end else if (p == m_phase) begin
      m_dwell++;
      if (m_dwell == MAX_D + 1) begin m_long = 1; m_phase = 0; end
    end else if (p == m_phase % 3 + 1) begin
      if (m_dwell < MIN_D && !m_exempt) begin
        m_short = 1; m_phase = 0;
      end else begin
        if (m_phase == 3) begin
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        m_phase = p; m_dwell = 1; m_exempt = 0;
      end
    end else begin
      m_seq = 1; m_phase = 0;
    end
    if (m_ill || m_seq || m_short || m_long) m_sticky = 1;
  endfunction

  task automatic step(input logic [2:0] l, input bit r);
    @(negedge clk);
    light = l;
    rst   = r;
    @(posedge clk);
    model_step(l, r);
    #1;
    check("cur_phase", phase_a, m_phase);
    check("err_illegal", ill_a, m_ill);
    check("err_sequence", seq_a, m_seq);
    check("err_dwell_short", short_a, m_short);
    check("err_dwell_long", long_a, m_long);
    check("err_sticky", sticky_a, m_sticky);
    check("cycle_count", cnt_a, m_cnt8);
    check("sat_cycle_count", cnt_b, m_cnt2);
    check("sat_cur_phase", phase_b, m_phase);
    check("err_at_most_one", int'(ill_a) + int'(seq_a) + int'(short_a) + int'(long_a) <= 1, 1);
  endtask

  task automatic run(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  initial begin
    logic [2:0] code;
    int len;
    light = 3'b000;
    rst   = 1'b1;

    // Reset state
    step(R, 1'b1);
    check("reset_phase", phase_a, 0);
    check("reset_count", cnt_a, 0);

    // Legal cycles, then four more; second instance saturates at 3
    run(R, 3); run(G, 3); run(Y, 3); step(R, 1'b0);
    check("tp_first_cycle", cnt_a, 1);
    check("tp_no_sticky", sticky_a, 0);
    for (int c = 0; c < 4; c++) begin
      run(R, 2); run(G, 3); run(Y, 3); step(R, 1'b0);
    end
    check("tp_five_cycles", cnt_a, 5);
    check("tp_saturated", cnt_b, 3);

    // Illegal code while in GREEN
    run(R, 1); run(G, 2);
    step(3'b110, 1'b0);
    check("tp_illegal_pulse", ill_a, 1);
    run(G, 1);
    check("tp_illegal_one_cycle", ill_a, 0);
    run(G, 3);
    check("tp_g_ignored", phase_a, 0);
    step(R, 1'b0);
    check("tp_resync", phase_a, 1);

    // Sequence error
    run(R, 2); step(Y, 1'b0);
    check("tp_seq_pulse", seq_a, 1);

    // Long dwell: pulses on the 17th and 34th RED samples
    run(R, 16);
    check("tp_no_long_yet", long_a, 0);
    step(R, 1'b0);
    check("tp_long_17", long_a, 1);
    run(R, 16);
    check("tp_no_long_33", long_a, 0);
    step(R, 1'b0);
    check("tp_long_34", long_a, 1);

    // Short dwell after a full legal cycle
    step(R, 1'b0); run(R, 2); run(G, 3); run(Y, 3); run(R, 3);
    step(G, 1'b0); step(Y, 1'b0);
    check("tp_short_pulse", short_a, 1);

    // Reset mid-operation while in YELLOW
    run(R, 2); run(G, 2); run(Y, 2);
    step(Y, 1'b1);
    check("tp_rst_phase", phase_a, 0);
    check("tp_rst_sticky", sticky_a, 0);
    step(Y, 1'b0);
    check("tp_rst_y_ignored", phase_a, 0);
    step(R, 1'b0);

    // Randomized runs biased toward legal progressions
    for (int k = 0; k < 500; k++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 75)      code = (m_phase == 0) ? R : (m_phase == 1 ? G : (m_phase == 2 ? Y : R));
      else if (sel < 88) begin
        case ($urandom_range(0, 2)) 0: code = R; 1: code = G; default: code = Y; endcase
      end else           code = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 1;
      else if (sel == 1) len = $urandom_range(15, 18);
      else               len = $urandom_range(MIN_D, 6);
      for (int i = 0; i < len; i++)
        step(code, ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the traffic-light lamp interface. It samples the one-hot lamp bus driven by the traffic-light controller and tracks the expected RED -> GREEN -> YELLOW -> RED sequence. It also enforces per-phase dwell bounds, counts completed cycles and raises error flags. It sits beside the controller in the top level and on the test bench, and never drives the lamp bus.

## Interface
- MIN_DWELL, 2: minimum consecutive samples each lamp must be held (>= 1).
- MAX_DWELL, 16: maximum consecutive samples each lamp may be held (> MIN_DWELL).
- CNT_W, 8: width of cycle_count.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- light_in  in  3  lamp bus {red,green,yellow}: 3'b100 RED, 3'b010 GREEN, 3'b001 YELLOW; all other codes illegal.
- cur_phase  out  2  tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW.
- err_illegal  out  1  one-cycle pulse: non-one-hot code sampled.
- err_sequence  out  1  one-cycle pulse: legal code out of order.
- err_dwell_short  out  1  one-cycle pulse: phase left before MIN_DWELL samples.
- err_dwell_long  out  1  one-cycle pulse: phase held MAX_DWELL+1 samples.
- err_sticky  out  1  OR of all errors since reset; cleared only by rst.
- cycle_count  out  CNT_W  completed legal cycles, saturating.

## Operation
- One clock; reset is synchronous and active-high. While rst is sampled high, all outputs go to 0 on that edge: cur_phase=SYNC, all err_* = 0, cycle_count = 0. Internal dwell counter also goes to 0.
- Reset applied mid-operation discards all history with no partial-cycle credit.
- All outputs are registered.
- Dwell counter: counts consecutive samples of the same legal code, including the first. It saturates at MAX_DWELL+1.
- SYNC state:
  - Legal non-RED codes are ignored, with no sequence or dwell checks.
  - Illegal codes still raise err_illegal.
  - Sampling RED moves to RED with dwell=1. This first phase after SYNC is exempt from the short-dwell check.
- RED, GREEN or YELLOW, per sample, in priority order (exactly one error per sample):
  1. Illegal code: err_illegal, go to SYNC.
  2. Same code as the current phase: dwell+1. If dwell reaches MAX_DWELL+1: err_dwell_long, go to SYNC.
  3. Expected successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED):
     - If the exiting phase dwell < MIN_DWELL and that phase is not exempt: err_dwell_short, go to SYNC.
     - Otherwise advance, dwell=1.
  4. Any other legal code: err_sequence, go to SYNC.
- cycle_count increments on an accepted YELLOW->RED transition and holds at 2^CNT_W-1.
- A failing sample never increments cycle_count.
- After any error the monitor re-synchronises on the next RED sample. The error sample itself is never reused as a sync point, even if it is RED.
- A lamp stuck at RED therefore pulses err_dwell_long once every MAX_DWELL+1 samples after the first sync.
- err_sticky is set in the same cycle as any error pulse.

## Timing
- Latency: light_in sampled at edge k is reflected in cur_phase, the err_* pulses, err_sticky and cycle_count after edge k (one cycle).
- Each err_* pulse is high for exactly one cycle per offending sample.
- At most one err_* pulse is asserted in any cycle.
- No handshake: light_in is assumed synchronous to clk and is sampled every cycle.
- rst takes priority over every event sampled in the same cycle.

## Test plan
Defaults MIN_DWELL=2, MAX_DWELL=16.
- Legal cycles:
  - Stimulus: rst 1 cycle, then R x3, G x3, Y x3, R.
  - Response: cur_phase 1,2,3,1; cycle_count 1; no err_*; err_sticky 0.
  - Then 4 more full cycles give cycle_count 5.
- Illegal code:
  - Stimulus: in GREEN, drive 3'b110 for 1 sample, then G x4, then R.
  - Response: err_illegal for exactly 1 cycle; cur_phase 0 with G ignored; err_sticky 1; cur_phase 1 after the R sample.
- Sequence error:
  - Stimulus: after sync, R x3 then Y.
  - Response: err_sequence pulse, cur_phase 0, cycle_count unchanged.
- Short and long dwell:
  - Stimulus: after a full legal cycle, G x1 then Y. Separately, R x17 after sync.
  - Response: err_dwell_short on the Y sample. err_dwell_long on the 17th R sample only, then again on the 34th with R held.
- Saturation:
  - Stimulus: CNT_W=2, 5 legal cycles.
  - Response: cycle_count 1,2,3,3,3.
- Reset mid-operation:
  - Stimulus: in YELLOW with cycle_count 5 and err_sticky 1, assert rst 1 cycle.
  - Response: next cycle cur_phase 0, cycle_count 0, err_sticky 0, no pulses. A following Y is ignored and R syncs.
